// File: rtl/vector_test_sequencer.sv
// Built-in self-test sequencer: applies a loadable vector table to a combinational DUT and
// counts mismatches. Define VTS_STOP_ON_ERR_EN to end a run at the first mismatch.
module vector_test_sequencer #(
    parameter int unsigned IN_W   = 3,
    parameter int unsigned OUT_W  = 1,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter int unsigned ERR_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [IN_W+OUT_W-1:0]   wr_data,
    input  logic [ADDR_W:0]         num_vectors,
    input  logic                    start,
    output logic [IN_W-1:0]         dut_in,
    input  logic [OUT_W-1:0]        dut_out,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [ERR_W-1:0]        err_count,
    output logic                    fail_valid,
    output logic [ADDR_W-1:0]       first_fail_idx,
    output logic [ADDR_W-1:0]       vec_idx
);

    typedef enum logic [1:0] {StIdle, StApply, StCheck, StDone} state_e;

    localparam logic [ADDR_W:0] NMax = (ADDR_W+1)'(DEPTH);

    logic [IN_W+OUT_W-1:0] table_q [DEPTH];

    state_e              state_q, state_d;
    logic [IN_W-1:0]     dut_in_q, dut_in_d;
    logic [OUT_W-1:0]    exp_q, exp_d;
    logic [ADDR_W-1:0]   vec_idx_q, vec_idx_d;
    logic [ADDR_W:0]     n_q, n_d;
    logic [ERR_W-1:0]    err_count_q, err_count_d;
    logic                fail_valid_q, fail_valid_d;
    logic [ADDR_W-1:0]   first_fail_idx_q, first_fail_idx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;

    logic                  idle_or_done;
    logic [ADDR_W:0]       n_clamped;
    logic [IN_W+OUT_W-1:0] entry;
    logic                  mismatch;
    logic                  last_vec;
    logic                  stop_run;

    assign idle_or_done = (state_q == StIdle) || (state_q == StDone);
    assign n_clamped    = (num_vectors > NMax) ? NMax : num_vectors;
    assign entry        = table_q[vec_idx_q];
    assign mismatch     = (dut_out != exp_q);
    assign last_vec     = ({1'b0, vec_idx_q} == (n_q - (ADDR_W+1)'(1)));

`ifdef VTS_STOP_ON_ERR_EN
    assign stop_run = mismatch;
`else
    assign stop_run = 1'b0;
`endif

    // Table is plain storage: not reset, and frozen while a run is in progress.
    always_ff @(posedge clk) begin
        if (wr_en && idle_or_done) begin
            table_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        state_d          = state_q;
        dut_in_d         = dut_in_q;
        exp_d            = exp_q;
        vec_idx_d        = vec_idx_q;
        n_d              = n_q;
        err_count_d      = err_count_q;
        fail_valid_d     = fail_valid_q;
        first_fail_idx_d = first_fail_idx_q;
        busy_d           = busy_q;
        done_d           = done_q;
        pass_d           = pass_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    vec_idx_d        = '0;
                    err_count_d      = '0;
                    fail_valid_d     = 1'b0;
                    first_fail_idx_d = '0;
                    n_d              = n_clamped;
                    if (n_clamped != '0) begin
                        state_d = StApply;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        pass_d  = 1'b0;
                    end else begin
                        state_d = StDone;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end
                end
            end
            StApply: begin
                dut_in_d = entry[IN_W+OUT_W-1 -: IN_W];
                exp_d    = entry[OUT_W-1:0];
                state_d  = StCheck;
            end
            StCheck: begin
                if (mismatch) begin
                    if (err_count_q != '1) begin
                        err_count_d = err_count_q + ERR_W'(1);
                    end
                    if (!fail_valid_q) begin
                        fail_valid_d     = 1'b1;
                        first_fail_idx_d = vec_idx_q;
                    end
                end
                if (last_vec || stop_run) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_count_d == '0);
                end else begin
                    vec_idx_d = vec_idx_q + ADDR_W'(1);
                    state_d   = StApply;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q          <= StIdle;
            dut_in_q         <= '0;
            exp_q            <= '0;
            vec_idx_q        <= '0;
            n_q              <= '0;
            err_count_q      <= '0;
            fail_valid_q     <= 1'b0;
            first_fail_idx_q <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            dut_in_q         <= dut_in_d;
            exp_q            <= exp_d;
            vec_idx_q        <= vec_idx_d;
            n_q              <= n_d;
            err_count_q      <= err_count_d;
            fail_valid_q     <= fail_valid_d;
            first_fail_idx_q <= first_fail_idx_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
        end
    end

    assign dut_in         = dut_in_q;
    assign vec_idx        = vec_idx_q;
    assign err_count      = err_count_q;
    assign fail_valid     = fail_valid_q;
    assign first_fail_idx = first_fail_idx_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;

endmodule

// File: tb/tb_vector_test_sequencer.sv
// Directed bench for vector_test_sequencer driving a y = a&b | c model; a second instance
// with a 2-bit error counter shares all inputs to exercise saturation.
module tb_vector_test_sequencer;

`ifdef VTS_STOP_ON_ERR_EN
    localparam bit Stop = 1'b1;
`else
    localparam bit Stop = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [3:0]  wr_data;
    logic [4:0]  num_vectors;
    logic        start;

    logic [2:0]  dut_in, dut_in_s;
    logic        dut_out, dut_out_s;
    logic        busy, done, pass, fail_valid;
    logic        busy_s, done_s, pass_s, fail_valid_s;
    logic [15:0] err_count;
    logic [1:0]  err_count_s;
    logic [3:0]  first_fail_idx, vec_idx, first_fail_idx_s, vec_idx_s;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic model(input logic [2:0] x);
        return (x[2] & x[1]) | x[0];
    endfunction

    assign dut_out   = model(dut_in);
    assign dut_out_s = model(dut_in_s);

    vector_test_sequencer u_dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .num_vectors(num_vectors), .start(start), .dut_in(dut_in), .dut_out(dut_out),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_valid(fail_valid), .first_fail_idx(first_fail_idx), .vec_idx(vec_idx)
    );

    vector_test_sequencer #(.ERR_W(2)) u_dut_small (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .num_vectors(num_vectors), .start(start), .dut_in(dut_in_s), .dut_out(dut_out_s),
        .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_count_s),
        .fail_valid(fail_valid_s), .first_fail_idx(first_fail_idx_s), .vec_idx(vec_idx_s)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Entry i holds inputs i[2:0]; expected is the model value, inverted where mask[i] is set.
    task automatic load(input logic [15:0] mask);
        for (int i = 0; i < 16; i++) begin
            logic [3:0] ia;
            ia      = 4'(i);
            wr_en   = 1'b1;
            wr_addr = ia;
            wr_data = {ia[2:0], model(ia[2:0]) ^ mask[i]};
            tick();
        end
        wr_en = 1'b0;
    endtask

    // Pulses start and waits for done. proto counts cycles where busy/done/dut_in
    // disagree with the expected schedule. At cycle inj a write to entry 2 and a
    // second start are attempted while busy.
    task automatic run(input int n, input int inj, output int cyc, output int proto);
        num_vectors = 5'(n);
        start       = 1'b1;
        cyc         = 0;
        proto       = 0;
        for (int c = 1; c <= 100; c++) begin
            tick();
            start = 1'b0;
            wr_en = 1'b0;
            if (done) begin
                cyc = c;
                break;
            end
            if (busy !== (n != 0)) proto++;
            if (busy_s !== busy) proto++;
            if ((c % 2) == 0 && dut_in !== 3'((c / 2) - 1)) proto++;
            if (c == inj) begin
                wr_en   = 1'b1;
                wr_addr = 4'd2;
                wr_data = {3'd2, ~model(3'd2)};
                start   = 1'b1;
            end
        end
        if (cyc == 0) $display("FAIL run_timeout: got no done expected done within 100 cycles");
        if (busy || done_s !== 1'b1) proto++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dut_in"}, 32'(dut_in), 0);
        check({tag, "_vec_idx"}, 32'(vec_idx), 0);
        check({tag, "_err_count"}, 32'(err_count), 0);
        check({tag, "_first_fail_idx"}, 32'(first_fail_idx), 0);
        check({tag, "_flags"}, 32'({busy, done, pass, fail_valid}), 0);
    endtask

    typedef struct {
        int          n;
        logic [15:0] mask;
        int          cycles;
        int          err;
        int          err_small;
        int          first;
        int          vec;
        logic        fv;
    } scen_t;

    scen_t sc [7];

    initial begin
        int cyc;
        int proto;

        sc[0] = '{8,  16'h0000, 17, 0, 0, 0, 7, 1'b0};
        sc[1] = '{8,  16'h0028, Stop ? 9 : 17, Stop ? 1 : 2, Stop ? 1 : 2, 3,
                  Stop ? 3 : 7, 1'b1};
        sc[2] = '{0,  16'h0000, 1, 0, 0, 0, 0, 1'b0};
        sc[3] = '{4,  16'h0020, 9, 0, 0, 0, 3, 1'b0};
        sc[4] = '{20, 16'h1000, Stop ? 27 : 33, 1, 1, 12, Stop ? 12 : 15, 1'b1};
        sc[5] = '{8,  16'h00FF, Stop ? 3 : 17, Stop ? 1 : 8, Stop ? 1 : 3, 0,
                  Stop ? 0 : 7, 1'b1};
        sc[6] = '{16, 16'h8000, 33, 1, 1, 15, 15, 1'b1};

        reset       = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        num_vectors = '0;
        start       = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        reset = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            string t;
            t = $sformatf("sc%0d", i);
            load(sc[i].mask);
            run(sc[i].n, 0, cyc, proto);
            check({t, "_cycles"}, 32'(cyc), 32'(sc[i].cycles));
            check({t, "_err_count"}, 32'(err_count), 32'(sc[i].err));
            check({t, "_err_count_sat"}, 32'(err_count_s), 32'(sc[i].err_small));
            check({t, "_pass"}, 32'(pass), 32'(sc[i].err == 0));
            check({t, "_fail_valid"}, 32'(fail_valid), 32'(sc[i].fv));
            check({t, "_protocol"}, 32'(proto), 0);
            if (sc[i].fv) check({t, "_first_fail_idx"}, 32'(first_fail_idx), 32'(sc[i].first));
            if (sc[i].n != 0) check({t, "_vec_idx"}, 32'(vec_idx), 32'(sc[i].vec));
        end

        // Reset during CHECK of vector 4, then a clean rerun.
        load(16'h0040);
        num_vectors = 5'd8;
        start       = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            start = 1'b0;
        end
        check("abort_pre_vec_idx", 32'(vec_idx), 4);
        check("abort_pre_busy", 32'(busy), 1);
        reset = 1'b0;
        tick();
        check_reset_outputs("abort");
        reset = 1'b1;
        run(8, 0, cyc, proto);
        check("rerun_cycles", 32'(cyc), Stop ? 15 : 17);
        check("rerun_err_count", 32'(err_count), 1);
        check("rerun_first_fail_idx", 32'(first_fail_idx), 6);
        check("rerun_protocol", 32'(proto), 0);

        // Write and start while busy are ignored; restart from DONE clears counts.
        run(8, 3, cyc, proto);
        check("busy_wr_cycles", 32'(cyc), Stop ? 15 : 17);
        check("busy_wr_err_count", 32'(err_count), 1);
        check("busy_wr_first_fail_idx", 32'(first_fail_idx), 6);
        check("busy_wr_protocol", 32'(proto), 0);
        run(8, 0, cyc, proto);
        check("restart_cycles", 32'(cyc), Stop ? 15 : 17);
        check("restart_err_count", 32'(err_count), 1);
        check("restart_dut_in_held", 32'(dut_in), Stop ? 6 : 7);

        // Write committed in the same cycle as start is seen by the first APPLY.
        wr_en   = 1'b1;
        wr_addr = 4'd0;
        wr_data = {3'd0, 1'b1};
        run(1, 0, cyc, proto);
        check("wr_start_cycles", 32'(cyc), 3);
        check("wr_start_err_count", 32'(err_count), 1);
        check("wr_start_first_fail_idx", 32'(first_fail_idx), 0);
        check("wr_start_pass", 32'(pass), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vector_test_sequencer.md
Name: vector_test_sequencer

Overview:
- Hardware self-test controller for small combinational blocks such as simplefunction.
- Holds a loadable table of test vectors. Each vector is an input pattern plus an expected output.
- On start, applies each vector to the attached DUT in turn, compares the DUT output against the expected value, and counts mismatches.
- Reports pass/fail, error count and first failing index. This is the synthesizable counterpart of the vector-driven simulation bench flow.

Parameters:
- IN_W, 3: DUT input width.
- OUT_W, 1: DUT output width.
- DEPTH, 16: vector table entries (power of two, >=2).
- ADDR_W, $clog2(DEPTH): table index width.
- ERR_W, 16: error counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- wr_en  in  1  table write strobe; honoured only in IDLE or DONE.
- wr_addr  in  ADDR_W  table write index.
- wr_data  in  IN_W+OUT_W  {inputs, expected}; inputs occupy the MSBs.
- num_vectors  in  ADDR_W+1  vectors to run (0..DEPTH); sampled on start.
- start  in  1  single-cycle run request.
- dut_in  out  IN_W  registered stimulus to the DUT.
- dut_out  in  OUT_W  DUT response (combinational DUT).
- busy  out  1  run in progress.
- done  out  1  run finished; held until next start or reset.
- pass  out  1  done && err_count==0.
- err_count  out  ERR_W  mismatch count, saturating.
- fail_valid  out  1  at least one mismatch this run.
- first_fail_idx  out  ADDR_W  index of the first mismatching vector.
- vec_idx  out  ADDR_W  vector currently applied.

Behaviour:
- Reset (reset==0 at posedge clk):
  - State goes to IDLE.
  - dut_in, vec_idx, err_count, first_fail_idx all 0; busy, done, pass, fail_valid all 0.
  - Table contents are not cleared.
- FSM states:
  - IDLE:
    - start with num_vectors>0 → APPLY. At the same time: vec_idx=0, err_count=0, fail_valid=0, latch num_vectors into n_q.
    - start with num_vectors==0 → DONE with zero counts, so pass=1.
  - APPLY:
    - dut_in <= table[vec_idx].inputs; exp_q <= table[vec_idx].expected.
    - Always → CHECK.
  - CHECK: dut_in has been stable for a full cycle; compare dut_out != exp_q.
    - On mismatch: err_count += 1, holding at 2^ERR_W-1 once saturated.
    - On the first mismatch only: fail_valid=1, first_fail_idx=vec_idx.
    - If vec_idx == n_q-1 → DONE; otherwise vec_idx += 1 → APPLY.
  - DONE:
    - done=1 and results are held.
    - start → restart exactly as from IDLE, clearing done and the counters.
- Timing:
  - 2 cycles per vector.
  - A run of N vectors asserts done 2N+1 cycles after the start cycle: 1 cycle entering, then APPLY/CHECK pairs, then the DONE transition.
- busy=1 in APPLY and CHECK only. busy and done are never both 1.
- start while busy is ignored.
- wr_en while busy is ignored; the table is unchanged.
- Simultaneous start and wr_en in IDLE/DONE: the write is committed, and the run's first APPLY (the next cycle) sees the new data.
- num_vectors > DEPTH is clamped to DEPTH.
- Reset mid-run aborts immediately to IDLE with all outputs at reset values.
- dut_in retains its last applied pattern in DONE.

Optional Feature:
- Macro: VTS_STOP_ON_ERR_EN.
- Defined: on the first mismatch, CHECK goes directly to DONE. In that case err_count=1, fail_valid=1, first_fail_idx=failing index, and vec_idx remains at the failing index.
- Undefined: all n_q vectors always run, as described in Behaviour.

Test Plan:
- Load 8 vectors that match the attached DUT model (y=a&b|c), num_vectors=8, pulse start → done rises 17 cycles after start; pass=1, err_count=0, fail_valid=0; dut_in steps through 0..7.
- Same table with entries 3 and 5 expected values inverted → err_count=2, first_fail_idx=3, pass=0. With VTS_STOP_ON_ERR_EN: done at cycle 9, err_count=1, vec_idx=3.
- num_vectors=0, start → done=1 the next cycle, pass=1, busy never asserted.
- Reset driven low during CHECK of vector 4, then high, then start with 8 vectors → all outputs 0 after reset; the rerun completes normally with correct counts.
- wr_en to index 2 and start pulsed while busy → table entry 2 unchanged and the run not restarted; a second start in DONE restarts with err_count cleared.
- ERR_W=2, 8 vectors all mismatching → err_count saturates at 3, first_fail_idx=0.
